// File: rtl/lsb_queue_pkg.sv
// Shared definitions for the load/store buffer: op encodings, size codes, tag sentinel, FSM states.
// Pure declarations; no timing or backpressure of its own.
package lsb_queue_pkg;

  localparam int LSB_SIZE = 16;
  localparam int XLEN_W   = 32;
  localparam int ROB_W    = 4;
  localparam int OP_W     = 6;

  // All-ones tag means "operand value already valid"; ROB tag 15 is never allocated.
  localparam logic [ROB_W-1:0] NO_DEP = '1;

  localparam logic [OP_W-1:0] OP_LB  = 6'd1;
  localparam logic [OP_W-1:0] OP_LH  = 6'd2;
  localparam logic [OP_W-1:0] OP_LW  = 6'd3;
  localparam logic [OP_W-1:0] OP_LBU = 6'd4;
  localparam logic [OP_W-1:0] OP_LHU = 6'd5;
  localparam logic [OP_W-1:0] OP_SB  = 6'd6;
  localparam logic [OP_W-1:0] OP_SH  = 6'd7;
  localparam logic [OP_W-1:0] OP_SW  = 6'd8;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_STORE_WAIT,
    ST_DRAIN
  } lsb_state_e;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [2:0] op_size(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsb_queue_load_ext.sv
// lsb_load_ext: sign/zero-extends raw load data according to the load op.
// Purely combinational, no backpressure.
module lsb_load_ext
  import lsb_queue_pkg::*;
#(
  parameter int XLEN = XLEN_W,
  parameter int OPW  = OP_W
) (
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rdata;
    case (op)
      OP_LB:   value = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      OP_LH:   value = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      OP_LBU:  value = {{(XLEN-8){1'b0}}, rdata[7:0]};
      OP_LHU:  value = {{(XLEN-16){1'b0}}, rdata[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer with CDB snooping, commit-gated stores and mispredict flush.
// Load ready at head -> CDB pulse in memctrl latency + 2 cycles; rdy low freezes everything, lsb_full throttles dispatch.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH = LSB_SIZE,
  parameter int XLEN  = XLEN_W,
  parameter int ROBW  = ROB_W,
  parameter int OPW   = OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            dsp_valid,
  input  logic [OPW-1:0]  dsp_op,
  input  logic [XLEN-1:0] dsp_vj,
  input  logic [XLEN-1:0] dsp_vk,
  input  logic [ROBW-1:0] dsp_qj,
  input  logic [ROBW-1:0] dsp_qk,
  input  logic [XLEN-1:0] dsp_imm,
  input  logic [ROBW-1:0] dsp_rob_id,
  input  logic            cdb_alu_valid,
  input  logic [ROBW-1:0] cdb_alu_rob_id,
  input  logic [XLEN-1:0] cdb_alu_value,
  input  logic            commit_valid,
  input  logic [ROBW-1:0] commit_rob_id,
  input  logic            mispredict,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_size,
  output logic            cdb_lsb_valid,
  output logic [ROBW-1:0] cdb_lsb_rob_id,
  output logic [XLEN-1:0] cdb_lsb_value,
  output logic            lsb_full
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic            busy;
    logic            committed;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] vj;
    logic [XLEN-1:0] vk;
    logic [XLEN-1:0] imm;
    logic [ROBW-1:0] qj;
    logic [ROBW-1:0] qk;
    logic [ROBW-1:0] rob_id;
  } ent_t;

  ent_t            ent [DEPTH];
  ent_t            hd, new_ent;
  logic [PW-1:0]   head, tail;
  logic [PW:0]     count, count_nxt, cc;
  lsb_state_e      state, state_nxt;
  logic            enq, pop, issue_ld, issue_st, fin_ld;
  logic [XLEN-1:0] ld_value;

  // ALU bus wins when both buses carry the awaited tag.
  function automatic logic [ROBW+XLEN-1:0] fwd(input logic [ROBW-1:0] q, input logic [XLEN-1:0] v);
    if (q != NO_DEP && cdb_alu_valid && q == cdb_alu_rob_id) return {NO_DEP, cdb_alu_value};
    if (q != NO_DEP && cdb_lsb_valid && q == cdb_lsb_rob_id) return {NO_DEP, cdb_lsb_value};
    return {q, v};
  endfunction

  assign hd  = ent[head];
  assign enq = dsp_valid && !mispredict;

  lsb_load_ext #(.XLEN(XLEN), .OPW(OPW)) u_ext (
    .op    (hd.op),
    .rdata (mem_rdata),
    .value (ld_value)
  );

  always_comb begin
    new_ent           = '0;
    new_ent.busy      = 1'b1;
    new_ent.op        = dsp_op;
    new_ent.imm       = dsp_imm;
    new_ent.rob_id    = dsp_rob_id;
    {new_ent.qj, new_ent.vj} = fwd(dsp_qj, dsp_vj);
    {new_ent.qk, new_ent.vk} = fwd(dsp_qk, dsp_vk);
  end

  // Committed stores always form a contiguous run starting at head.
  always_comb begin
    cc = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent[i].busy && ent[i].committed) cc = cc + (PW+1)'(1);
  end

  always_comb begin
    state_nxt = state;
    issue_ld  = 1'b0;
    issue_st  = 1'b0;
    pop       = 1'b0;
    fin_ld    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!mispredict && hd.busy) begin
          if (is_load(hd.op) && hd.qj == NO_DEP) begin
            issue_ld  = 1'b1;
            state_nxt = ST_LOAD_WAIT;
          end else if (is_store(hd.op) && hd.committed && hd.qj == NO_DEP && hd.qk == NO_DEP) begin
            issue_st  = 1'b1;
            state_nxt = ST_STORE_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (mispredict) begin
          state_nxt = mem_done ? ST_IDLE : ST_DRAIN;
        end else if (mem_done) begin
          pop       = 1'b1;
          fin_ld    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_STORE_WAIT: begin
        if (mem_done) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if (mispredict) count_nxt = cc - (PW+1)'(pop);
    else            count_nxt = count + (PW+1)'(enq) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      state          <= ST_IDLE;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_size       <= '0;
      cdb_lsb_valid  <= 1'b0;
      cdb_lsb_rob_id <= '0;
      cdb_lsb_value  <= '0;
      lsb_full       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      count    <= count_nxt;
      lsb_full <= (count_nxt >= (PW+1)'(DEPTH-1));

      for (int i = 0; i < DEPTH; i++) begin
        {ent[i].qj, ent[i].vj} <= fwd(ent[i].qj, ent[i].vj);
        {ent[i].qk, ent[i].vk} <= fwd(ent[i].qk, ent[i].vk);
        if (commit_valid && ent[i].busy && is_store(ent[i].op) && ent[i].rob_id == commit_rob_id)
          ent[i].committed <= 1'b1;
        if (mispredict && !ent[i].committed)
          ent[i].busy <= 1'b0;
      end
      if (pop) begin
        ent[head].busy      <= 1'b0;
        ent[head].committed <= 1'b0;
        head                <= head + PW'(1);
      end
      if (enq) ent[tail] <= new_ent;

      if (mispredict) tail <= head + cc[PW-1:0];
      else if (enq)   tail <= tail + PW'(1);

      if (issue_ld || issue_st) begin
        mem_req   <= 1'b1;
        mem_we    <= issue_st;
        mem_addr  <= hd.vj + hd.imm;
        mem_wdata <= hd.vk;
        mem_size  <= op_size(hd.op);
      end else if (mem_done && state != ST_IDLE) begin
        mem_req <= 1'b0;
      end

      cdb_lsb_valid <= fin_ld;
      if (fin_ld) begin
        cdb_lsb_rob_id <= hd.rob_id;
        cdb_lsb_value  <= ld_value;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rdy && dsp_valid && count == (PW+1)'(DEPTH)));

endmodule
